// File: rtl/gb80_memory_responder.sv
// gb80_memory_responder: gb80 CPU memory target serving HRAM, IE, the unusable window and a wait-stated external port
module gb80_memory_responder #(
  parameter int unsigned EXT_WAIT_CYCLES = 2,
  parameter logic [15:0] HRAM_BASE = 16'hFF80,
  parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [15:0] i_req_addr,
  input  logic        i_req_we,
  input  logic [7:0]  i_req_wdata,
  output logic        o_rsp_valid,
  output logic [7:0]  o_rsp_data,
  output logic [7:0]  o_ie,
  output logic        o_ext_en,
  output logic        o_ext_we,
  output logic [15:0] o_ext_addr,
  output logic [7:0]  o_ext_wdata,
  input  logic [7:0]  i_ext_rdata
);
  typedef enum logic [1:0] {IDLE, EXT, RESP} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [15:0] addr_r;
  logic we_r;
  logic [7:0] wdata_r, ie;
  logic [7:0] hram [0:126];
  logic accept, hram_hit, ie_hit, bad_hit, local_hit;
  logic [15:0] off;
  logic [7:0] local_rd;
  assign accept = i_req_valid && o_req_ready;
  assign hram_hit = i_req_addr >= HRAM_BASE && i_req_addr < IE_ADDR;
  assign ie_hit = i_req_addr == IE_ADDR;
  assign bad_hit = i_req_addr >= 16'hFEA0 && i_req_addr <= 16'hFEFF;
  assign local_hit = hram_hit || ie_hit || bad_hit;
  assign off = i_req_addr - HRAM_BASE;
  assign local_rd = ie_hit ? ie : hram_hit ? hram[off[6:0]] : 8'hFF;
  assign o_req_ready = state == IDLE;
  assign o_rsp_valid = state == RESP;
  assign o_ext_en = state == EXT;
  assign o_ext_we = o_ext_en && we_r;
  assign o_ext_addr = addr_r;
  assign o_ext_wdata = wdata_r;
  assign o_ie = ie;
  // next state: local hits answer next cycle, external ones wait for the counter to expire
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (accept ? (local_hit ? RESP : EXT) : IDLE) :
                (state == EXT)  ? ((cnt == 4'd0) ? RESP : EXT) : IDLE;
  end
  // state register; reset aborts any access in flight
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else state <= state_nxt;
  end
  // request capture, wait counter, IE register and response data
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt <= 4'd0;
      addr_r <= 16'h0000;
      we_r <= 1'b0;
      wdata_r <= 8'h00;
      ie <= 8'h00;
      o_rsp_data <= 8'h00;
    end else if (accept) begin
      addr_r <= i_req_addr;
      we_r <= i_req_we;
      wdata_r <= i_req_wdata;
      cnt <= 4'(EXT_WAIT_CYCLES);
      if (local_hit) o_rsp_data <= i_req_we ? i_req_wdata : local_rd;
      if (ie_hit && i_req_we) ie <= i_req_wdata;
    end else if (state == EXT) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd0) o_rsp_data <= we_r ? wdata_r : i_ext_rdata;
    end
  end
  // HRAM array, deliberately not reset
  always_ff @(posedge i_clk) begin
    if (accept && hram_hit && i_req_we && !i_reset) hram[off[6:0]] <= i_req_wdata;
  end
endmodule

// File: doc/gb80_memory_responder.md
Name: gb80_memory_responder

Overview:
- Target side of the gb80 processor memory interface: services byte read/write requests issued by the CPU core.
- Decodes the 16-bit address map and serves three kinds of location:
  - internal high RAM (HRAM, 0xFF80-0xFFFE);
  - the interrupt-enable register IE (0xFFFF);
  - the unusable window 0xFEA0-0xFEFF.
- Every other address is forwarded to an external memory port with a fixed, parameterised wait-state count.
- Returns exactly one response pulse per accepted request.

Parameters:
- EXT_WAIT_CYCLES, 2, extra cycles o_ext_en is held before external read data is sampled (0..15).
- HRAM_BASE, 16'hFF80, first HRAM address.
- IE_ADDR, 16'hFFFF, address of the IE register.

Ports:
- i_clk  input  1  system clock, all state on rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_req_valid  input  1  CPU request present
- o_req_ready  output  1  responder can accept a request this cycle
- i_req_addr  input  16  byte address
- i_req_we  input  1  1 = write, 0 = read
- i_req_wdata  input  8  write data
- o_rsp_valid  output  1  one-cycle response strobe
- o_rsp_data  output  8  read data; for writes, the written byte echoed back
- o_ie  output  8  current IE register contents, to the interrupt logic
- o_ext_en  output  1  external access active
- o_ext_we  output  1  external write strobe, qualified by o_ext_en
- o_ext_addr  output  16  external address, held stable while o_ext_en = 1
- o_ext_wdata  output  8  external write data
- i_ext_rdata  input  8  external read data

Behaviour:
- Reset (asynchronous, effective immediately):
  - state = IDLE; o_req_ready = 1; o_rsp_valid = 0; o_rsp_data = 8'h00.
  - o_ext_en = 0; o_ext_we = 0; o_ext_addr = 16'h0000; o_ext_wdata = 8'h00.
  - IE = 8'h00.
  - HRAM contents are not reset.
- Acceptance: a request is accepted on a rising edge with i_req_valid = 1 and o_req_ready = 1. Address, we and wdata are registered at that edge; request inputs are don't-care afterwards.
- o_req_ready = 1 only in IDLE, so there is at most one outstanding request. i_req_valid while not ready is ignored; the CPU must hold it.
- States are IDLE, EXT, RESP.
- Local access (HRAM, IE, or the unusable window), accepted at edge N:
  - IDLE -> RESP.
  - o_rsp_valid = 1 during cycle N+1, then -> IDLE.
  - HRAM: 127 x 8 array indexed by addr - HRAM_BASE; reads return the stored byte and writes update it at edge N.
  - IE: writes take effect at edge N, so o_ie shows the new value from N+1; reads return IE.
  - Unusable window 0xFEA0-0xFEFF: reads return 8'hFF; writes are discarded.
- External access, accepted at edge N:
  - IDLE -> EXT.
  - o_ext_en = 1, with addr/we/wdata driven, for exactly EXT_WAIT_CYCLES+1 cycles (N+1 .. N+EXT_WAIT_CYCLES+1).
  - A 4-bit wait counter loads EXT_WAIT_CYCLES on accept and decrements in EXT.
  - When the counter is 0: i_ext_rdata is sampled into o_rsp_data (reads) and the state -> RESP.
  - o_rsp_valid is high during cycle N+EXT_WAIT_CYCLES+2.
  - For writes, o_ext_we = o_ext_en for the whole window.
- RESP always lasts one cycle; o_ext_en is 0 in RESP. There is no response backpressure.
- Back-to-back: o_req_ready is 1 again in the cycle after RESP, so the minimum spacing between accepts is 2 cycles (local) or EXT_WAIT_CYCLES+3 cycles (external).
- o_rsp_data holds its last value when o_rsp_valid = 0.
- Reset mid-access aborts the access:
  - o_ext_en drops immediately; no response is issued.
  - IE clears.
  - An HRAM write already clocked in remains.
- Address decode is on the full 16 bits; 0xFF80 and 0xFFFE are both HRAM, and 0xFF7F is external.

Test Plan:
- After reset release, read 0xFFFF -> o_rsp_valid high 1 cycle after accept with o_rsp_data = 8'h00; o_ie = 8'h00.
- Write 8'hA5 to 0xFF80, then 8'h3C to 0xFFFE, then read both -> each write acks in 1 cycle with its echo; reads return 8'hA5 and 8'h3C.
- EXT_WAIT_CYCLES = 2, read 0xC000 with i_ext_rdata = 8'h5A:
  - o_ext_en high for exactly 3 cycles with o_ext_addr = 16'hC000;
  - o_rsp_valid at accept+4 with data 8'h5A;
  - o_req_ready low throughout.
- Write 8'h1F to 0xFFFF -> o_ie = 8'h1F from the next cycle; a read of 0xFEB0 returns 8'hFF; a write of 8'h00 to 0xFEB0 changes nothing.
- Hold i_req_valid continuously with alternating addresses 0xFF90 / 0x8000 -> one response per request; no accept while busy; responses arrive in order.
- Assert i_reset during the second EXT cycle of a write to 0xD000 -> o_ext_en and o_ext_we drop asynchronously, no o_rsp_valid, o_req_ready = 1 after release.
